// File: rtl/ahb_burst_sequencer.sv
// -----------------------------------------------------------------------------
// ahb_burst_sequencer
//
// Turns one AXI address-channel command (addr/len/size/burst) into the AHB
// address-phase sequence for it, one beat per accepted address phase.
// INCR commands are cut into legal AHB bursts (INCR16/8/4, SINGLE or undefined
// length INCR) and never cross a 1KB boundary. WRAP commands map onto
// WRAP4/8/16, and 2-beat wraps become two SINGLE transfers. FIXED commands
// repeat the start address as SINGLE transfers.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   cmd_valid     command present
//   cmd_ready     command accepted when cmd_valid & cmd_ready (high in IDLE)
//   cmd_addr      start address
//   cmd_len       beats - 1
//   cmd_size      log2 bytes per beat
//   cmd_burst     00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//   cmd_write     1 = write
//   hready        AHB ready; the address phase advances only when high
//   htrans        00 IDLE, 10 NONSEQ, 11 SEQ
//   haddr         beat address
//   hburst        AHB burst code of the current chunk
//   hsize/hwrite  copies of cmd_size / cmd_write
//   beat_last     high with the final address phase of the command
//   busy          command in progress
//   cmd_error     one-cycle pulse when a command is rejected
// -----------------------------------------------------------------------------
module ahb_burst_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int LEN_W    = 8,
  parameter int MAX_SIZE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  input  logic              cmd_write,
  input  logic              hready,
  output logic [1:0]        htrans,
  output logic [ADDR_W-1:0] haddr,
  output logic [2:0]        hburst,
  output logic [2:0]        hsize,
  output logic              hwrite,
  output logic              beat_last,
  output logic              busy,
  output logic              cmd_error
);

  // Beat counters are one bit wider than the length field so that an
  // all-ones length (maximum beat count) is representable.
  localparam int RW = LEN_W + 1;
  // Width for the 1KB-distance arithmetic; at least 12 bits for up to 1024 beats.
  localparam int CW = (RW > 12) ? RW : 12;

  localparam logic [1:0] BT_FIXED = 2'b00;
  localparam logic [1:0] BT_INCR  = 2'b01;
  localparam logic [1:0] BT_WRAP  = 2'b10;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  localparam logic [2:0] HB_SINGLE = 3'b000;
  localparam logic [2:0] HB_INCR   = 3'b001;
  localparam logic [2:0] HB_WRAP4  = 3'b010;
  localparam logic [2:0] HB_INCR4  = 3'b011;
  localparam logic [2:0] HB_WRAP8  = 3'b100;
  localparam logic [2:0] HB_INCR8  = 3'b101;
  localparam logic [2:0] HB_WRAP16 = 3'b110;
  localparam logic [2:0] HB_INCR16 = 3'b111;

  typedef enum logic {S_IDLE, S_ADDR} state_t;

  typedef struct packed {
    logic [4:0] beats;  // beats in this chunk, 1..16
    logic [2:0] code;   // hburst for this chunk
  } chunk_t;

  // Decides the AHB burst that starts at a chunk boundary. Only the low ten
  // address bits matter because only the distance to the next 1KB line counts.
  function automatic chunk_t chunk_calc(input logic [9:0]    a_lo,
                                        input logic [RW-1:0] rem,
                                        input logic [2:0]    sz,
                                        input logic [1:0]    bt);
    chunk_t         c;
    logic [CW-1:0]  off;
    logic [CW-1:0]  to1k;
    logic [CW-1:0]  avail;
    c.beats = 5'd1;
    c.code  = HB_SINGLE;
    off     = '0;
    to1k    = '0;
    avail   = '0;
    if (bt == BT_INCR) begin
      off   = CW'(11'h400 - {1'b0, a_lo});
      // Rounding up covers an unaligned start whose first beat is partial.
      to1k  = (off + ((CW'(1) << sz) - CW'(1))) >> sz;
      avail = (CW'(rem) < to1k) ? CW'(rem) : to1k;
      if (avail >= CW'(16)) begin
        c.beats = 5'd16;
        c.code  = HB_INCR16;
      end else if (avail >= CW'(8)) begin
        c.beats = 5'd8;
        c.code  = HB_INCR8;
      end else if (avail >= CW'(4)) begin
        c.beats = 5'd4;
        c.code  = HB_INCR4;
      end else if (avail != CW'(1)) begin
        c.beats = 5'(avail);
        c.code  = HB_INCR;
      end
    end else if (bt == BT_WRAP) begin
      // Whole command is one chunk, except a 2-beat wrap which AHB cannot
      // express and which therefore goes out as SINGLE transfers.
      if (rem == RW'(4)) begin
        c.beats = 5'd4;
        c.code  = HB_WRAP4;
      end else if (rem == RW'(8)) begin
        c.beats = 5'd8;
        c.code  = HB_WRAP8;
      end else if (rem == RW'(16)) begin
        c.beats = 5'd16;
        c.code  = HB_WRAP16;
      end
    end
    return c;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RW-1:0]     rem_q, rem_d;      // beats left including the current one
  logic [4:0]        chunk_q, chunk_d;  // chunk beats left including the current one
  logic [1:0]        burst_q, burst_d;
  logic [ADDR_W-1:0] wmask_q, wmask_d;  // wrap window size - 1
  logic [1:0]        htrans_q, htrans_d;
  logic [2:0]        hburst_q, hburst_d;
  logic [2:0]        hsize_q, hsize_d;
  logic              hwrite_q, hwrite_d;
  logic              last_q, last_d;
  logic              err_q, err_d;

  // Command-side decode
  logic [RW-1:0]     cmd_beats;
  logic [ADDR_W-1:0] cmd_step;
  logic              wrap_len_ok;
  logic              cmd_bad;
  chunk_t            ch_start;

  assign cmd_beats   = {1'b0, cmd_len} + RW'(1);
  assign cmd_step    = ADDR_W'(1) << cmd_size;
  assign wrap_len_ok = (cmd_len == LEN_W'(1))  || (cmd_len == LEN_W'(3)) ||
                       (cmd_len == LEN_W'(7))  || (cmd_len == LEN_W'(15));
  assign cmd_bad     = (cmd_burst == 2'b11) ||
                       (cmd_size > 3'(MAX_SIZE)) ||
                       ((cmd_burst == BT_WRAP) &&
                        (!wrap_len_ok || ((cmd_addr & (cmd_step - ADDR_W'(1))) != '0)));
  assign ch_start    = chunk_calc(cmd_addr[9:0], cmd_beats, cmd_size, cmd_burst);

  // Beat-side address generation
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] next_addr;
  logic [RW-1:0]     rem_dec;
  chunk_t            ch_next;

  assign step    = ADDR_W'(1) << hsize_q;
  assign rem_dec = rem_q - RW'(1);

  always_comb begin
    // NOTE: a default on every path keeps this block purely combinational;
    // a missing else branch here would infer a latch.
    next_addr = addr_q;
    case (burst_q)
      // Only the first beat may be unaligned; later beats snap to the size grid.
      BT_INCR: next_addr = (addr_q & ~(step - ADDR_W'(1))) + step;
      BT_WRAP: next_addr = (addr_q & ~wmask_q) | ((addr_q + step) & wmask_q);
      default: next_addr = addr_q;
    endcase
  end

  assign ch_next = chunk_calc(next_addr[9:0], rem_dec, hsize_q, burst_q);

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    chunk_d  = chunk_q;
    burst_d  = burst_q;
    wmask_d  = wmask_q;
    htrans_d = htrans_q;
    hburst_d = hburst_q;
    hsize_d  = hsize_q;
    hwrite_d = hwrite_q;
    last_d   = last_q;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            state_d  = S_ADDR;
            addr_d   = cmd_addr;
            rem_d    = cmd_beats;
            chunk_d  = ch_start.beats;
            burst_d  = cmd_burst;
            wmask_d  = (ADDR_W'(cmd_beats) << cmd_size) - ADDR_W'(1);
            htrans_d = HT_NONSEQ;
            hburst_d = ch_start.code;
            hsize_d  = cmd_size;
            hwrite_d = cmd_write;
            last_d   = (cmd_len == '0);
          end
        end
      end
      S_ADDR: begin
        // With hready low nothing moves, so every output holds.
        if (hready) begin
          if (last_q) begin
            state_d  = S_IDLE;
            htrans_d = HT_IDLE;
            last_d   = 1'b0;
          end else begin
            addr_d = next_addr;
            rem_d  = rem_dec;
            last_d = (rem_dec == RW'(1));
            if (chunk_q == 5'd1) begin
              chunk_d  = ch_next.beats;
              hburst_d = ch_next.code;
              htrans_d = HT_NONSEQ;
            end else begin
              chunk_d  = chunk_q - 5'd1;
              htrans_d = HT_SEQ;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      chunk_q  <= '0;
      burst_q  <= '0;
      wmask_q  <= '0;
      htrans_q <= HT_IDLE;
      hburst_q <= '0;
      hsize_q  <= '0;
      hwrite_q <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      chunk_q  <= chunk_d;
      burst_q  <= burst_d;
      wmask_q  <= wmask_d;
      htrans_q <= htrans_d;
      hburst_q <= hburst_d;
      hsize_q  <= hsize_d;
      hwrite_q <= hwrite_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_ADDR);
  assign htrans    = htrans_q;
  assign haddr     = addr_q;
  assign hburst    = hburst_q;
  assign hsize     = hsize_q;
  assign hwrite    = hwrite_q;
  assign beat_last = last_q;
  assign cmd_error = err_q;

endmodule
